writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage; the write-side counterpart of the decode stage's register-file read ports.
- Registers results from execute/memory and performs load-data extraction (byte/half/word, signed/unsigned).
- Selects the write-back result and drives the register-file write port (write enable, destination address, data).
- Holds the upstream pipeline with a ready/valid handshake while a load waits on a variable-latency data memory.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers an instruction this cycle.
- in_ready  output  1  unit accepts an instruction this cycle.
- in_reg_write  input  1  instruction writes rd.
- in_rd  input  ADDR_WIDTH  destination register.
- in_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- in_mem_size  input  2  00 byte, 01 half, 10/11 word.
- in_mem_signed  input  1  1 = sign-extend load, 0 = zero-extend.
- in_alu_result  input  DATA_WIDTH  ALU result / load address.
- in_pc_plus4  input  DATA_WIDTH  link value.
- in_imm_ext  input  DATA_WIDTH  extended immediate.
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  DATA_WIDTH  aligned 32-bit memory word.
- flush  input  1  kill the in-flight instruction.
- wb_en  output  1  register-file write enable.
- wb_rd  output  ADDR_WIDTH  register-file write address.
- wb_data  output  DATA_WIDTH  register-file write data.
- busy  output  1  load outstanding.
- stall_cycles  output  16  saturating count of cycles spent in WAIT_MEM.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; wb_en, wb_rd, wb_data, busy, stall_cycles all 0. Captured instruction fields cleared.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready && !flush.
- in_ready: combinational, 1 in IDLE and COMMIT, 0 in WAIT_MEM.

State machine (IDLE, WAIT_MEM, COMMIT):
- IDLE/COMMIT, accept with in_result_src != 01 → COMMIT. wb_data gets the selected source; wb_en = in_reg_write && (in_rd != 0); wb_rd = in_rd.
- IDLE/COMMIT, accept of a load → WAIT_MEM. Capture rd, reg_write, size, signed and alu_result[1:0]. Set busy = 1; wb_en = 0.
- IDLE/COMMIT, no accept → IDLE; wb_en = 0.
- WAIT_MEM, flush = 1 → IDLE; no write; busy = 0. Flush wins over a simultaneous mem_rvalid.
- WAIT_MEM, mem_rvalid = 1 → COMMIT. wb_data = formatted load; wb_en per captured reg_write && rd != 0; busy = 0.
- WAIT_MEM, otherwise: stay; stall_cycles += 1, saturating at 0xFFFF.
- mem_rvalid outside WAIT_MEM is ignored.

Timing and write pulse:
- Latency: non-load, 1 cycle (wb_en high in the cycle after accept). Load, 1 cycle after the mem_rvalid edge.
- wb_en is a single-cycle pulse per instruction; back-to-back non-loads give wb_en high on consecutive cycles.

Load formatting (offset = captured alu_result[1:0]):
- Byte: lane = mem_rdata[8*offset +: 8].
- Half: lane = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0]; offset[0] is ignored (misaligned half is not trapped).
- Word: full mem_rdata; offset ignored.
- Extension: sign-extend the lane if signed, else zero-extend.

Flush and reset corner cases:
- Flush in IDLE/COMMIT blocks the accept that cycle; the wb_en of an already-registered instruction still fires.
- Reset mid-load aborts it; a later mem_rvalid is ignored.

Test Plan:
- ALU op: in_result_src=00, alu_result=0x0000_002A, rd=5, reg_write=1 → next cycle wb_en=1, wb_rd=5, wb_data=0x2A; following cycle wb_en=0.
- Signed byte load: size=00, signed=1, alu_result=...3, mem_rdata=0x80FF_1234 after 3 wait cycles → busy=1 and in_ready=0 for 3 cycles; then wb_data=0xFFFF_FF80, stall_cycles=3.
- Unsigned half load: size=01, signed=0, offset 2, mem_rdata=0xBEEF_0001 → wb_data=0x0000_BEEF. LUI: src=11, imm=0x1234_5000 → wb_data=0x1234_5000. JAL: src=10, pc_plus4=0x104 → wb_data=0x104.
- rd=0 or reg_write=0 → wb_en never asserts; the load still completes and busy clears.
- Flush and mem_rvalid in the same cycle during WAIT_MEM → no wb_en, state IDLE, in_ready=1 next cycle.
- Assert rst while in WAIT_MEM → all outputs 0 immediately without a clock edge. Release rst, then pulse mem_rvalid → no write.

Source files
------------

// File: rtl/writeback_unit.sv
// Final pipeline stage: registers execute/memory results, formats load data and
// drives the register-file write port, holding upstream while a load is outstanding.
module writeback_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [1:0]            in_result_src,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_signed,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_pc_plus4,
    input  logic [DATA_WIDTH-1:0] in_imm_ext,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  flush,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy,
    output logic [15:0]           stall_cycles
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_COMMIT   = 2'd2;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [1:0]            state_q, state_d;
    logic                  wb_en_q, wb_en_d;
    logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  busy_q, busy_d;
    logic [15:0]           stall_cycles_q, stall_cycles_d;

    logic [ADDR_WIDTH-1:0] cap_rd_q, cap_rd_d;
    logic                  cap_reg_write_q, cap_reg_write_d;
    logic [1:0]            cap_size_q, cap_size_d;
    logic                  cap_signed_q, cap_signed_d;
    logic [1:0]            cap_offset_q, cap_offset_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] direct_result;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_data;

    assign in_ready = (state_q != ST_WAIT_MEM);
    assign accept   = in_valid && in_ready && !flush;

    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign busy         = busy_q;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        direct_result = in_alu_result;
        case (in_result_src)
            SRC_ALU: direct_result = in_alu_result;
            SRC_PC4: direct_result = in_pc_plus4;
            2'b11:   direct_result = in_imm_ext;
            default: direct_result = in_alu_result;
        endcase
    end

    // Lane selection uses the address offset captured at accept time, not the live input.
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (cap_offset_q)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = cap_offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_data = mem_rdata;
        case (cap_size_q)
            SIZE_BYTE: load_data = cap_signed_q ? {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane}
                                                : {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            SIZE_HALF: load_data = cap_signed_q ? {{(DATA_WIDTH-16){half_lane[15]}}, half_lane}
                                                : {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default:   load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        wb_en_d         = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        busy_d          = busy_q;
        stall_cycles_d  = stall_cycles_q;
        cap_rd_d        = cap_rd_q;
        cap_reg_write_d = cap_reg_write_q;
        cap_size_d      = cap_size_q;
        cap_signed_d    = cap_signed_q;
        cap_offset_d    = cap_offset_q;

        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                if (accept) begin
                    if (in_result_src == SRC_LOAD) begin
                        state_d         = ST_WAIT_MEM;
                        cap_rd_d        = in_rd;
                        cap_reg_write_d = in_reg_write;
                        cap_size_d      = in_mem_size;
                        cap_signed_d    = in_mem_signed;
                        cap_offset_d    = in_alu_result[1:0];
                        busy_d          = 1'b1;
                    end else begin
                        state_d   = ST_COMMIT;
                        wb_en_d   = in_reg_write && (in_rd != '0);
                        wb_rd_d   = in_rd;
                        wb_data_d = direct_result;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Flush takes priority so a killed load never writes, even if data arrives together.
            ST_WAIT_MEM: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (mem_rvalid) begin
                    state_d   = ST_COMMIT;
                    wb_en_d   = cap_reg_write_q && (cap_rd_q != '0);
                    wb_rd_d   = cap_rd_q;
                    wb_data_d = load_data;
                    busy_d    = 1'b0;
                end else if (stall_cycles_q != 16'hFFFF) begin
                    stall_cycles_d = stall_cycles_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            wb_en_q         <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            busy_q          <= 1'b0;
            stall_cycles_q  <= '0;
            cap_rd_q        <= '0;
            cap_reg_write_q <= 1'b0;
            cap_size_q      <= '0;
            cap_signed_q    <= 1'b0;
            cap_offset_q    <= '0;
        end else begin
            state_q         <= state_d;
            wb_en_q         <= wb_en_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            busy_q          <= busy_d;
            stall_cycles_q  <= stall_cycles_d;
            cap_rd_q        <= cap_rd_d;
            cap_reg_write_q <= cap_reg_write_d;
            cap_size_q      <= cap_size_d;
            cap_signed_q    <= cap_signed_d;
            cap_offset_q    <= cap_offset_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued as instructions
// (or load data) are driven and popped whenever the unit raises wb_en.
module tb_writeback_unit;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_result_src;
    logic [1:0]  in_mem_size;
    logic        in_mem_signed;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_imm_ext;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic [15:0] stall_cycles;

    wb_t         sbQueue[$];
    int          checkCount;
    int          errorCount;
    logic [15:0] expStall;
    logic [1:0]  loadSize;
    logic        loadSigned;
    logic [1:0]  loadOffset;
    logic [4:0]  loadRd;
    logic        loadRegWrite;

    writeback_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_result_src (in_result_src),
        .in_mem_size   (in_mem_size),
        .in_mem_signed (in_mem_signed),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_imm_ext    (in_imm_ext),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy          (busy),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] expectLoad(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> (8 * int'(off));
        b = shifted[7:0];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
        if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        return rdata;
    endfunction

    // Drives one instruction for exactly one accept edge; caller must ensure in_ready is high.
    task automatic applyStimulus(input logic [1:0] src, input logic [4:0] rd, input logic regWrite,
                                 input logic [1:0] size, input logic sgn, input logic [31:0] alu,
                                 input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] sel;
        logic        expWrite;
        in_valid      = 1'b1;
        in_result_src = src;
        in_rd         = rd;
        in_reg_write  = regWrite;
        in_mem_size   = size;
        in_mem_signed = sgn;
        in_alu_result = alu;
        in_pc_plus4   = pc;
        in_imm_ext    = imm;
        sel = (src == 2'b10) ? pc : (src == 2'b11) ? imm : alu;
        expWrite = (src != 2'b01) && regWrite && (rd != 5'd0);
        if (expWrite) sbQueue.push_back('{rd: rd, data: sel});
        if (src == 2'b01) begin
            loadSize = size; loadSigned = sgn; loadOffset = alu[1:0];
            loadRd = rd; loadRegWrite = regWrite;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("wb_en_latency", {31'b0, wb_en}, {31'b0, expWrite});
    endtask

    task automatic completeLoad(input int waitCycles, input logic [31:0] rdata);
        logic expWrite;
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("busy_wait", {31'b0, busy}, 32'd1);
            checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        expStall = (expStall > 16'hFFFF - 16'(waitCycles)) ? 16'hFFFF : expStall + 16'(waitCycles);
        expWrite = loadRegWrite && (loadRd != 5'd0);
        if (expWrite) sbQueue.push_back('{rd: loadRd, data: expectLoad(loadSize, loadSigned, loadOffset, rdata)});
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        checkOutput("load_wb_en", {31'b0, wb_en}, {31'b0, expWrite});
        checkOutput("load_busy_clear", {31'b0, busy}, 32'd0);
        checkOutput("stall_cycles", {16'b0, stall_cycles}, {16'b0, expStall});
    endtask

    always @(negedge clk) begin
        if (rst && wb_en) begin
            checkOutput("wb_pending", {31'b0, (sbQueue.size() != 0)}, 32'd1);
            if (sbQueue.size() != 0) begin
                wb_t e;
                e = sbQueue.pop_front();
                checkOutput("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                checkOutput("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] srcSel;
        checkCount = 0; errorCount = 0; expStall = 16'd0;
        loadSize = 2'b00; loadSigned = 1'b0; loadOffset = 2'b00; loadRd = 5'd0; loadRegWrite = 1'b0;
        rst = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = 5'd0; in_result_src = 2'b00;
        in_mem_size = 2'b00; in_mem_signed = 1'b0; in_alu_result = 32'd0; in_pc_plus4 = 32'd0;
        in_imm_ext = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_en", {31'b0, wb_en}, 32'd0);
        checkOutput("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_stall", {16'b0, stall_cycles}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // ALU result, then a quiet cycle to confirm the write is a single pulse.
        applyStimulus(2'b00, 5'd5, 1'b1, 2'b10, 1'b0, 32'h0000_002A, 32'h0, 32'h0);
        @(posedge clk); #1;
        checkOutput("wb_en_pulse", {31'b0, wb_en}, 32'd0);

        applyStimulus(2'b01, 5'd6, 1'b1, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h0);
        completeLoad(3, 32'h80FF_1234);
        checkOutput("sbyte_stall3", {16'b0, stall_cycles}, 32'd3);
        applyStimulus(2'b01, 5'd7, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h0);
        completeLoad(1, 32'hBEEF_0001);

        applyStimulus(2'b11, 5'd8, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1234_5000);
        applyStimulus(2'b10, 5'd1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0104, 32'h0);
        for (int i = 0; i < 6; i++) begin
            srcSel = 2'($urandom_range(0, 2));
            applyStimulus((srcSel == 2'd0) ? 2'b00 : (srcSel == 2'd1) ? 2'b10 : 2'b11,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'b10, 1'b0,
                          $urandom, $urandom, $urandom);
        end

        // Loads that must complete without writing.
        applyStimulus(2'b01, 5'd0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        completeLoad(2, 32'h1111_2222);
        applyStimulus(2'b01, 5'd9, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        completeLoad(2, 32'h3333_4444);

        applyStimulus(2'b01, 5'd10, 1'b1, 2'b01, 1'b1, 32'h0000_0003, 32'h0, 32'h0);
        completeLoad(0, 32'h8001_7FFF);
        applyStimulus(2'b01, 5'd11, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
        completeLoad(1, 32'h1234_F6AB);
        applyStimulus(2'b01, 5'd12, 1'b1, 2'b11, 1'b1, 32'h0000_0002, 32'h0, 32'h0);
        completeLoad(2, 32'hCAFE_F00D);
        applyStimulus(2'b01, 5'd13, 1'b1, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 32'h0);
        completeLoad(0, 32'h0000_007F);

        // Flush and data arriving together while waiting: flush wins.
        applyStimulus(2'b01, 5'd14, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        expStall = expStall + 16'd1;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        flush = 1'b0; mem_rvalid = 1'b0;
        checkOutput("flush_wb_en", {31'b0, wb_en}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_stall", {16'b0, stall_cycles}, {16'b0, expStall});
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checkOutput("stray_rvalid", {31'b0, wb_en}, 32'd0);

        // Flush in COMMIT blocks the new accept but not the registered write.
        applyStimulus(2'b00, 5'd15, 1'b1, 2'b10, 1'b0, 32'h0000_0F0F, 32'h0, 32'h0);
        in_valid = 1'b1; flush = 1'b1; in_result_src = 2'b00; in_rd = 5'd16; in_reg_write = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_blocks_accept", {31'b0, wb_en}, 32'd0);

        // Reset mid-load clears everything without a clock edge.
        applyStimulus(2'b01, 5'd17, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, busy}, 32'd0);
        checkOutput("arst_wb_data", wb_data, 32'd0);
        checkOutput("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("arst_stall", {16'b0, stall_cycles}, 32'd0);
        checkOutput("arst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        expStall = 16'd0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checkOutput("post_rst_rvalid", {31'b0, wb_en}, 32'd0);
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", sbQueue.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
